la_step_sequencer: RTL and testbench
====================================

Name: la_step_sequencer

Overview:
User-project stage inside the user project wrapper. It takes commands from the management core over the logic analyzer (LA) bus and drives a 2-bit step code onto mprj_io[1:0]. The chip-level LA bench monitors these pins as checkbits and expects the sequence 0,1,2,3,0. Status is returned to firmware on la_data_out.

Parameters:
DIV_W, 24, width of the per-step hold period field/counter
STEP_W, 8, width of step limit and step counter
IO_W, 38, width of io_out/io_oeb (matches mprj_io)

Ports:
wb_clk_i  in  1  system clock
resetb  in  1  asynchronous active-low reset
la_data_in  in  64  LA command word from management core
la_oenb  in  64  LA output-enable-bar; bit valid only when 0
la_data_out  out  64  status to management core
io_out  out  IO_W  pad outputs; [1:0] = step code
io_oeb  out  IO_W  pad output-enable-bar

Behaviour:
- One clock domain, wb_clk_i. Reset is asynchronous and active-low on resetb.
- Effective LA bit: la_data_in[i] & ~la_oenb[i]. A masked bit reads as 0.
- Command fields:
  - en = bit 0
  - start = bit 1
  - period = bits [8+DIV_W-1:8]
  - limit = bits [39:32]
- Start detection:
  - start_q registers effective bit 1.
  - start_pulse = start & ~start_q.
- FSM states: IDLE, RUN, DONE.
  - IDLE: code=0, div=0, steps=0. Goes to RUN on start_pulse & en.
  - RUN:
    - div counts 0..P-1, where P = max(period,1).
    - When div==P-1: div←0, steps←steps+1, code←code+1 mod 4.
    - If limit≠0 and steps+1==limit on that advance: go to DONE, code←0.
    - limit==0 means free-run.
  - DONE: code=0, done=1. start_pulse & en re-enters RUN with div, steps and code cleared.
  - Any state with en==0 goes to IDLE on the next edge. en low has priority over start_pulse and over a step advance in the same cycle.
- Timing: code 0 is held for P cycles after entering RUN, so every code value lasts exactly P cycles.
- Period or limit changed mid-RUN: takes effect immediately.
  - New P ≤ current div: div wraps at its maximum.
  - Firmware must stop (en=0) before reprogramming.
- steps saturates at all-ones when free-running. code keeps wrapping.
- Outputs:
  - io_out[1:0]=code; io_out[IO_W-1:2]=0.
  - io_oeb[1:0]=0; io_oeb[IO_W-1:2]=all 1.
  - la_data_out: [1:0]=code, [2]=running (state==RUN), [3]=done, [11:4]=steps, [63:12]=0.
  - All outputs are registered or derived from registers. No combinational path from la_data_in to io_out.
- Reset values:
  - state=IDLE; code, div, steps, start_q = 0.
  - io_out=0, io_oeb[1:0]=0, la_data_out=0.
  - Reset asserted mid-RUN: outputs return to these values immediately (asynchronous).

Optional Feature:
Macro LA_SEQ_IRQ_EN.
- Defined: adds output port user_irq, 3 bits.
  - user_irq[0] is a registered one-cycle pulse on each RUN→DONE transition.
  - user_irq[2:1]=0.
  - Reset value 0.
- Undefined: port absent, no IRQ logic.

Test Plan:
1. Reset only, no LA activity → io_out=0, io_oeb[1:0]=0, io_oeb[37:2]=all 1, la_data_out=0.
2. period=10, limit=4, en=1, start 0→1 → code 0,1,2,3 each held 10 cycles, then 0. la_data_out[3]=1, steps=4, running=0.
3. Same command with la_oenb[1]=1 → start masked; stays IDLE, code 0 for 1000 cycles.
4. period=0, limit=0, start → code advances every cycle 0,1,2,3,0,1…. Drop en → next edge IDLE, code 0, steps 0.
5. period=5, limit=8; assert resetb=0 mid-RUN at code=2 → io_out[1:0]=0 and la_data_out=0 without waiting for a clock edge. After release, stays IDLE until a new start edge.
6. With LA_SEQ_IRQ_EN: scenario 2 → user_irq[0] high exactly one cycle, coincident with DONE entry. Restart from DONE via new start edge → done cleared, sequence repeats.

Source files
------------

// File: rtl/la_step_sequencer_if.sv
// la_step_sequencer_if: LA command/status and pad bundle between the management core and the step sequencer.
interface la_step_sequencer_if #(parameter int IO_W = 38);
   logic [63:0]     la_data_in;
   logic [63:0]     la_oenb;
   logic [63:0]     la_data_out;
   logic [IO_W-1:0] io_out;
   logic [IO_W-1:0] io_oeb;
   modport master (output la_data_in, la_oenb, input la_data_out, io_out, io_oeb);
   modport slave (input la_data_in, la_oenb, output la_data_out, io_out, io_oeb);
endinterface

// File: rtl/la_step_sequencer.sv
// la_step_sequencer: LA-commanded 2-bit step code generator driving mprj_io[1:0].
// Define LA_SEQ_IRQ_EN to add the user_irq port pulsing on each RUN->DONE transition.
module la_step_sequencer #(
   parameter int DIV_W  = 24,
   parameter int STEP_W = 8,
   parameter int IO_W   = 38
) (
   input logic wb_clk_i,
   input logic resetb,
   la_step_sequencer_if.slave bus
`ifdef LA_SEQ_IRQ_EN
   ,
   output logic [2:0] user_irq
`endif
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d, period, p_max;
   logic [STEP_W-1:0] steps_q, steps_d, limit;
   logic [1:0]        code_q, code_d;
   logic              start_q, en, start, go, adv, last;
   logic              unused_ok;
   assign en     = bus.la_data_in[0] & ~bus.la_oenb[0];
   assign start  = bus.la_data_in[1] & ~bus.la_oenb[1];
   assign period = bus.la_data_in[8 +: DIV_W] & ~bus.la_oenb[8 +: DIV_W];
   assign limit  = bus.la_data_in[32 +: STEP_W] & ~bus.la_oenb[32 +: STEP_W];
   assign unused_ok = ^{bus.la_data_in[63:40], bus.la_data_in[7:2], bus.la_oenb[63:40], bus.la_oenb[7:2]};
   assign go    = en & start & ~start_q;
   assign p_max = (period == '0) ? '0 : period - DIV_W'(1);
   assign adv   = div_q == p_max;
   assign last  = (limit != '0) && (STEP_W'(steps_q + 1'b1) == limit);
   // en low wins over everything; a start edge only matters outside RUN.
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      steps_d = steps_q;
      code_d  = code_q;
      if (!en) begin
         state_d = IDLE;
         div_d   = '0;
         steps_d = '0;
         code_d  = '0;
      end else if (state_q != RUN) begin
         if (go) begin
            state_d = RUN;
            div_d   = '0;
            steps_d = '0;
            code_d  = '0;
         end
      end else if (adv) begin
         div_d   = '0;
         steps_d = &steps_q ? steps_q : steps_q + 1'b1;
         state_d = last ? DONE : RUN;
         code_d  = last ? 2'd0 : code_q + 2'd1;
      end else begin
         div_d = div_q + 1'b1;
      end
   end
`ifdef LA_SEQ_IRQ_EN
   logic irq_q;
   always_ff @(posedge wb_clk_i or negedge resetb)
      if (!resetb) irq_q <= 1'b0;
      else         irq_q <= (state_q == RUN) && (state_d == DONE);
   assign user_irq = {2'b00, irq_q};
`endif
   always_ff @(posedge wb_clk_i or negedge resetb)
      if (!resetb) begin
         state_q <= IDLE;
         div_q   <= '0;
         steps_q <= '0;
         code_q  <= '0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         steps_q <= steps_d;
         code_q  <= code_d;
         start_q <= start;
      end
   assign bus.io_out      = {{(IO_W-2){1'b0}}, code_q};
   assign bus.io_oeb      = {{(IO_W-2){1'b1}}, 2'b00};
   assign bus.la_data_out = {{(64-4-STEP_W){1'b0}}, steps_q, state_q == DONE, state_q == RUN, code_q};
endmodule

// File: tb/tb_la_step_sequencer.sv
// tb_la_step_sequencer: directed plus randomized LA command stimulus checked against a time-based model of the step sequence.
module tb_la_step_sequencer;
   logic clk = 1'b0;
   logic resetb = 1'b0;
   always #5 clk = ~clk;
   la_step_sequencer_if #(.IO_W(38)) bus();
`ifdef LA_SEQ_IRQ_EN
   logic [2:0] user_irq;
`endif
   la_step_sequencer #(.DIV_W(24), .STEP_W(8), .IO_W(38)) dut (
      .wb_clk_i(clk),
      .resetb(resetb),
      .bus(bus)
`ifdef LA_SEQ_IRQ_EN
      ,
      .user_irq(user_irq)
`endif
   );
   logic        en_b, st_b, mask;
   logic [23:0] per;
   logic [7:0]  lim;
   bit          active, sq;
   int          t0, mp, ml, cyc, n_cmp, n_bad;
   task automatic drive();
      bus.la_data_in = {24'($urandom), lim, per, 6'($urandom), st_b, en_b};
      bus.la_oenb    = {24'($urandom), 8'h00, 24'h0, 6'($urandom), mask, 1'b0};
   endtask
   // Expected outputs follow from elapsed cycles since the last RUN entry.
   task automatic expect_now(output logic [1:0] c, output logic [7:0] s, output logic d, output logic r, output logic irq);
      int n, pe, k;
      c = 0; s = 0; d = 0; r = 0; irq = 0;
      if (active) begin
         n   = cyc - 1 - t0;
         pe  = (mp == 0) ? 1 : mp;
         k   = n / pe;
         d   = (ml != 0) && (k >= ml);
         r   = !d;
         c   = d ? 2'd0 : 2'(k % 4);
         s   = d ? 8'(ml) : ((k > 255) ? 8'd255 : 8'(k));
         irq = (ml != 0) && (n == ml * pe);
      end
   endtask
   task automatic check(input string tag);
      logic [1:0] c;
      logic [7:0] s;
      logic d, r, irq;
      expect_now(c, s, d, r, irq);
      n_cmp++;
      assert (bus.io_out === {36'b0, c}) else begin
         n_bad++;
         $error("FAIL %s io_out got %h want %h", tag, bus.io_out, {36'b0, c});
      end
      n_cmp++;
      assert (bus.io_oeb === {{36{1'b1}}, 2'b00}) else begin
         n_bad++;
         $error("FAIL %s io_oeb got %h want %h", tag, bus.io_oeb, {{36{1'b1}}, 2'b00});
      end
      n_cmp++;
      assert (bus.la_data_out === {52'b0, s, d, r, c}) else begin
         n_bad++;
         $error("FAIL %s la_data_out got %h want %h", tag, bus.la_data_out, {52'b0, s, d, r, c});
      end
`ifdef LA_SEQ_IRQ_EN
      n_cmp++;
      assert (user_irq === {2'b00, irq}) else begin
         n_bad++;
         $error("FAIL %s user_irq got %h want %h", tag, user_irq, {2'b00, irq});
      end
`endif
   endtask
   task automatic tick(input string tag);
      logic [1:0] c;
      logic [7:0] s;
      logic d, r, irq;
      bit st_e;
      @(posedge clk);
      st_e = st_b & ~mask;
      if (!resetb) begin
         active = 0;
         sq = 0;
      end else begin
         expect_now(c, s, d, r, irq);
         if (!en_b) active = 0;
         else if (st_e && !sq && (!active || d)) begin
            active = 1;
            t0 = cyc;
            mp = int'(per);
            ml = int'(lim);
         end
         sq = st_e;
      end
      cyc++;
      @(negedge clk);
      check(tag);
   endtask
   initial begin
      n_cmp = 0; n_bad = 0; cyc = 0; t0 = 0; mp = 0; ml = 0; active = 0; sq = 0;
      en_b = 0; st_b = 0; mask = 0; per = 0; lim = 0;
      drive();
      repeat (3) tick("in_reset");
      resetb = 1'b1;
      repeat (5) tick("reset_idle");
      per = 10; lim = 4; en_b = 1; drive();
      tick("seq_arm");
      st_b = 1; drive();
      repeat (45) tick("seq_p10_l4");
      n_cmp++;
      assert (bus.la_data_out === 64'h48) else begin
         n_bad++;
         $error("FAIL done_status la_data_out got %h want %h", bus.la_data_out, 64'h48);
      end
      en_b = 0; st_b = 0; drive();
      tick("stop");
      en_b = 1; drive();
      tick("mask_arm");
      st_b = 1; mask = 1; drive();
      repeat (1000) tick("masked_start");
      en_b = 0; st_b = 0; mask = 0; per = 0; lim = 0; drive();
      tick("stop2");
      en_b = 1; drive();
      tick("free_arm");
      st_b = 1; drive();
      repeat (300) tick("free_run");
      en_b = 0; drive();
      tick("en_drop");
      st_b = 0; per = 5; lim = 8; drive();
      tick("stop3");
      en_b = 1; drive();
      tick("rst_arm");
      st_b = 1; drive();
      repeat (12) tick("pre_reset");
      #2 resetb = 1'b0;
      active = 0; sq = 0;
      #1 check("async_reset");
      st_b = 0; drive();
      tick("held_reset");
      resetb = 1'b1;
      repeat (20) tick("post_reset_idle");
      st_b = 1; drive();
      repeat (50) tick("post_reset_run");
      for (int seg = 0; seg < 40; seg++) begin
         en_b = 0; st_b = 1'($urandom); mask = ($urandom % 4) == 0;
         per = 24'($urandom_range(0, 6)); lim = 8'($urandom_range(0, 6)); drive();
         tick("rnd_stop");
         en_b = 1;
         repeat ($urandom_range(5, 60)) begin
            if ($urandom % 6 == 0) st_b = ~st_b;
            if ($urandom % 8 == 0) mask = 1'($urandom);
            drive();
            tick("rnd_run");
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
